queen_solve_sequencer: RTL and testbench
========================================

Name: queen_solve_sequencer

Overview:
Host-side controller that sequences one run of the 8-queens solver core. It pulses the core's reset and then its start, and waits for done or No_Answer under a cycle-count watchdog. It then reads the 8 board rows one at a time through a row-select mux and streams them out over a valid/ready interface. It sits between the host request logic and the solver top; the solver's own controller and datapath are untouched.

Parameters:
ROWS, 8, number of board rows streamed per solution; index width is $clog2(ROWS).
TIMEOUT_CYCLES, 100000, maximum WAIT-state cycles before declaring timeout; 0 disables the watchdog.

Ports:
clk  input  1  single clock; all logic is rising-edge.
reset  input  1  synchronous, active-high reset.
req  input  1  request to run one solve; sampled only in IDLE.
busy  output  1  high in every state except IDLE.
solver_rst  output  1  one-cycle reset pulse to the solver core.
solver_start  output  1  one-cycle start pulse to the solver core.
solver_done  input  1  solver found a solution; level, held until the solver is reset.
solver_no_answer  input  1  solver exhausted the search; level.
rd_sel  output  3  row index into the solver's board-row mux.
rd_row  input  [0:7]  combinational board row selected by rd_sel; bit 0 is column 0.
out_valid  output  1  out_row, out_idx and row_last are valid.
out_ready  input  1  consumer accepts the row when out_valid && out_ready.
out_row  output  [0:7]  registered board row.
out_idx  output  3  row number of out_row.
row_last  output  1  out_valid && out_idx==ROWS-1.
status_no_answer  output  1  sticky; the last run ended with no answer.
status_timeout  output  1  sticky; the last run hit the watchdog.

Behaviour:
- Reset values: every output is 0, state is IDLE, the row index and watchdog counter are 0.
- reset takes effect at any time, including mid-run or mid-stream. The partial stream is abandoned with no row_last. The solver core must share the same reset.
- FSM states: IDLE, CLR, START, WAIT, READ, SEND.
- IDLE: when req=1 → CLR, and status_no_answer and status_timeout are cleared on the same edge. When req=0 → stay in IDLE.
- CLR: solver_rst=1 for exactly one cycle → START.
- START: solver_start=1 for exactly one cycle → WAIT. The watchdog counter is cleared.
- WAIT: the watchdog increments each cycle. Priority order for exits:
  - solver_no_answer=1 → set status_no_answer, go to IDLE. This wins over a simultaneous solver_done.
  - else solver_done=1 → READ with row index 0.
  - else, when TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 → set status_timeout, go to IDLE.
- READ: rd_sel = row index. rd_row is captured into out_row, and out_idx is loaded with the row index → SEND.
- SEND: out_valid=1. out_row and out_idx stay stable until the handshake.
  - On out_valid && out_ready, if the index is ROWS-1 → IDLE.
  - Otherwise the index increments → READ.
  - out_ready has no effect outside SEND.
- rd_sel holds its last value outside READ and is driven with the current index during READ and SEND.
- Latency:
  - First out_valid rises 2 cycles after the cycle in which solver_done is sampled high.
  - After each handshake, the next out_valid rises 2 cycles later, so the stream runs at most one row per 2 cycles.
  - busy falls on the edge after the last handshake.
- req while busy is ignored and is not queued. A new req may start in the first IDLE cycle after completion.
- solver_done and solver_no_answer are ignored outside WAIT.
- The index does not wrap inside a run; it returns to 0 only via READ entry from WAIT or via reset.
- Status flags change only on req acceptance, on a WAIT exit, or on reset.

Test Plan:
1. Normal solve: reset, then req=1 for 1 cycle. Expect solver_rst then solver_start high for one cycle each. Solver model raises done after 50 cycles, out_ready=1 throughout. Expect 8 rows with out_idx 0..7, out_row matching the model board (e.g. row0=8'b1000_0000, row1=8'b0000_1000), row_last only on idx 7, busy low 1 cycle after the final handshake.
2. Backpressure: same as 1 with out_ready low for 5 cycles on idx 3. Expect out_valid held and out_row/out_idx stable for all 5 cycles, no row skipped or duplicated, and the total stream still 8 rows.
3. No answer: the solver model raises no_answer after 20 cycles. Expect status_no_answer=1, no out_valid, and a return to IDLE. The next req clears status_no_answer.
4. Timeout and simultaneous events: with TIMEOUT_CYCLES=16 and no response, expect status_timeout=1 after exactly 16 WAIT cycles. In a separate run, raise done and no_answer in the same cycle; expect status_no_answer=1 and no stream.
5. Reset mid-stream: assert reset in SEND at idx 4. Next cycle expect all outputs 0 and IDLE. A fresh req afterwards produces a complete 8-row stream starting at idx 0.
6. req while busy: pulse req during WAIT and during SEND. Expect no extra solver_rst or solver_start pulses and exactly one 8-row stream.

Source files
------------

// File: rtl/queen_solve_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : queen_solve_sequencer
// Brief    : Runs one 8-queens solve under a watchdog, then streams the board
//            rows out over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module queen_solve_sequencer #(
   parameter int ROWS           = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req,
   output logic                      busy,
   output logic                      solver_rst,
   output logic                      solver_start,
   input  logic                      solver_done,
   input  logic                      solver_no_answer,
   output logic [$clog2(ROWS)-1:0]   rd_sel,
   input  logic [0:7]                rd_row,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [0:7]                out_row,
   output logic [$clog2(ROWS)-1:0]   out_idx,
   output logic                      row_last,
   output logic                      status_no_answer,
   output logic                      status_timeout
);

   localparam int IW  = $clog2(ROWS);
   localparam int WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [IW-1:0]  c_last_idx = IW'(ROWS - 1);
   localparam logic [WDW-1:0] c_wd_last  = WDW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLR   = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_READ  = 3'd4,
      S_SEND  = 3'd5
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IW-1:0]    r_idx;
   logic [WDW-1:0]   r_wdog;
   logic [0:7]       r_out_row;
   logic [IW-1:0]    r_out_idx;
   logic             r_status_na;
   logic             r_status_to;
   logic             w_wd_expire;
   logic             w_idx_last;

   assign w_wd_expire = (TIMEOUT_CYCLES != 0) && (r_wdog == c_wd_last);
   assign w_idx_last  = (r_idx == c_last_idx);

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      busy         = 1'b1;
      solver_rst   = 1'b0;
      solver_start = 1'b0;
      out_valid    = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (req) w_state_nxt = S_CLR;
         end
         S_CLR: begin
            solver_rst  = 1'b1;
            w_state_nxt = S_START;
         end
         S_START: begin
            solver_start = 1'b1;
            w_state_nxt  = S_WAIT;
         end
         S_WAIT: begin
            // no_answer outranks done; the watchdog only fires when neither is seen
            if (solver_no_answer)  w_state_nxt = S_IDLE;
            else if (solver_done)  w_state_nxt = S_READ;
            else if (w_wd_expire)  w_state_nxt = S_IDLE;
         end
         S_READ: w_state_nxt = S_SEND;
         S_SEND: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = w_idx_last ? S_IDLE : S_READ;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_idx       <= '0;
         r_wdog      <= '0;
         r_out_row   <= '0;
         r_out_idx   <= '0;
         r_status_na <= 1'b0;
         r_status_to <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req) begin
                  r_status_na <= 1'b0;
                  r_status_to <= 1'b0;
               end
            end
            S_START: r_wdog <= '0;
            S_WAIT: begin
               r_wdog <= r_wdog + 1'b1;
               if (solver_no_answer)  r_status_na <= 1'b1;
               else if (solver_done)  r_idx <= '0;
               else if (w_wd_expire)  r_status_to <= 1'b1;
            end
            S_READ: begin
               r_out_row <= rd_row;
               r_out_idx <= r_idx;
            end
            S_SEND: begin
               if (out_ready && !w_idx_last) r_idx <= r_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign rd_sel           = r_idx;
   assign out_row          = r_out_row;
   assign out_idx          = r_out_idx;
   assign row_last         = out_valid && (r_out_idx == c_last_idx);
   assign status_no_answer = r_status_na;
   assign status_timeout   = r_status_to;

endmodule
`default_nettype wire

// File: tb/tb_queen_solve_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_queen_solve_sequencer
// Brief    : Scoreboard bench for queen_solve_sequencer with a behavioural solver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_queen_solve_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req = 1'b0;
   logic       busy, solver_rst, solver_start;
   logic       solver_done = 1'b0, solver_no_answer = 1'b0;
   logic [2:0] rd_sel;
   logic [0:7] rd_row;
   logic       out_valid, row_last, status_no_answer, status_timeout;
   logic       out_ready = 1'b1;
   logic [0:7] out_row;
   logic [2:0] out_idx;

   // Second instance with a short watchdog and a silent solver
   logic       req2 = 1'b0;
   logic       z0 = 1'b0;
   logic       z1 = 1'b1;
   logic [0:7] z_row = '0;
   logic       busy2, rst2, start2, valid2, last2, na2, to2;
   logic [2:0] rd_sel2, out_idx2;
   logic [0:7] out_row2;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int n_rst = 0, n_start = 0, n_rows = 0, n_stall = 0;
   int t_ref = 0, t_idle = -1;
   int m_dly = 50, m_mode = 0, m_cnt = 0;
   bit m_armed = 1'b0;
   bit p_done = 1'b0, p_valid = 1'b0, p_stall = 1'b0;
   logic [2:0]  h_idx;
   logic [0:7]  h_row;
   logic [10:0] sb[$];

   // Queen column per row: 0,4,7,5,2,6,1,3 (bit 0 = column 0)
   logic [7:0] exp_rows [8] = '{8'b1000_0000, 8'b0000_1000, 8'b0000_0001, 8'b0000_0100,
                                8'b0010_0000, 8'b0000_0010, 8'b0100_0000, 8'b0001_0000};
   int         cols [8] = '{0, 4, 7, 5, 2, 6, 1, 3};

   function automatic logic [0:7] board_row(input logic [2:0] i);
      logic [0:7] r;
      r = '0;
      r[cols[i]] = 1'b1;
      return r;
   endfunction

   assign rd_row = board_row(rd_sel);

   queen_solve_sequencer u_dut (
      .clk(clk), .reset(reset), .req(req), .busy(busy),
      .solver_rst(solver_rst), .solver_start(solver_start),
      .solver_done(solver_done), .solver_no_answer(solver_no_answer),
      .rd_sel(rd_sel), .rd_row(rd_row), .out_valid(out_valid), .out_ready(out_ready),
      .out_row(out_row), .out_idx(out_idx), .row_last(row_last),
      .status_no_answer(status_no_answer), .status_timeout(status_timeout)
   );

   queen_solve_sequencer #(.ROWS(8), .TIMEOUT_CYCLES(16)) u_dut_to (
      .clk(clk), .reset(reset), .req(req2), .busy(busy2),
      .solver_rst(rst2), .solver_start(start2),
      .solver_done(z0), .solver_no_answer(z0),
      .rd_sel(rd_sel2), .rd_row(z_row), .out_valid(valid2), .out_ready(z1),
      .out_row(out_row2), .out_idx(out_idx2), .row_last(last2),
      .status_no_answer(na2), .status_timeout(to2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Behavioural solver: answers m_dly cycles after start; mode 0 done, 1 no_answer, 2 both
   initial begin
      forever begin
         @(posedge clk); #1;
         if (reset || solver_rst) begin
            solver_done = 1'b0; solver_no_answer = 1'b0; m_armed = 1'b0;
         end else if (solver_start) begin
            m_armed = 1'b1; m_cnt = 0;
         end else if (m_armed) begin
            m_cnt++;
            if (m_cnt == m_dly) begin
               m_armed = 1'b0;
               if (m_mode != 1) solver_done = 1'b1;
               if (m_mode != 0) solver_no_answer = 1'b1;
            end
         end
      end
   end

   // Output monitor and scoreboard consumer
   always @(negedge clk) begin
      logic [10:0] e;
      if (solver_rst)   n_rst++;
      if (solver_start) n_start++;
      if (solver_done && !p_done && busy) t_ref = cyc;
      if (out_valid && !p_valid) chk("valid_gap", cyc - t_ref, 2);
      if (out_valid) chk("row_last", row_last, out_idx == 3'd7);
      if (p_stall) begin
         chk("hold_valid", out_valid, 1);
         chk("hold_idx", out_idx, h_idx);
         chk("hold_row", out_row, h_row);
      end
      if (cyc == t_idle) begin
         chk("busy_fall", busy, 0);
         t_idle = -1;
      end
      if (out_valid && !out_ready) n_stall++;
      if (out_valid && out_ready) begin
         n_rows++;
         if (sb.size() == 0) chk("extra_row", 1, 0);
         else begin
            e = sb.pop_front();
            chk("row_idx", out_idx, e[10:8]);
            chk("row_data", out_row, e[7:0]);
         end
         t_ref = cyc;
         if (out_idx == 3'd7) t_idle = cyc + 1;
      end
      p_stall = out_valid && !out_ready;
      h_idx   = out_idx;
      h_row   = out_row;
      p_done  = solver_done;
      p_valid = out_valid;
   end

   task automatic push_rows();
      for (int i = 0; i < 8; i++) sb.push_back({3'(i), exp_rows[i]});
   endtask

   task automatic run(input int dly, input int mode);
      int n;
      m_dly = dly; m_mode = mode;
      if (mode == 0) push_rows();
      @(posedge clk); #1 req = 1'b1;
      @(posedge clk); #1 req = 1'b0;
      chk("acc_busy", busy, 1);
      chk("clr_na", status_no_answer, 0);
      chk("clr_to", status_timeout, 0);
      chk("rst_pulse", solver_rst, 1);
      @(posedge clk); #1;
      chk("start_pulse", solver_start, 1);
      chk("rst_drop", solver_rst, 0);
      n = 0;
      while (busy && n < 1000) begin
         @(posedge clk); #1; n++;
      end
      if (busy) chk("run_bound", 0, 1);
      chk("sb_drained", sb.size(), 0);
   endtask

   task automatic wait_row(input logic [2:0] idx);
      int n;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!(out_valid && out_idx == idx) && n < 500);
      if (!(out_valid && out_idx == idx)) chk("row_wait", 0, 1);
   endtask

   initial begin
      int r0, s0, st0, n;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_outs", {solver_rst, solver_start, out_valid, row_last, status_no_answer, status_timeout}, 0);
      chk("rst_data", {rd_sel, out_idx, out_row}, 0);
      chk("rst2_outs", {busy2, rst2, start2, valid2, last2, na2, to2}, 0);

      // Normal solve
      r0 = n_rows;
      run(50, 0);
      chk("t1_rows", n_rows - r0, 8);
      chk("t1_status", {status_no_answer, status_timeout}, 0);

      // Backpressure on row 3
      r0 = n_rows; st0 = n_stall;
      fork
         run(50, 0);
         begin
            wait_row(3'd3);
            out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      chk("t2_rows", n_rows - r0, 8);
      chk("t2_stall", n_stall - st0, 5);

      // No answer, then the next request clears the flag
      r0 = n_rows;
      run(20, 1);
      chk("t3_na", status_no_answer, 1);
      chk("t3_rows", n_rows - r0, 0);
      run(50, 0);
      chk("t3_na_clr", status_no_answer, 0);

      // Watchdog on the short-timeout instance
      @(posedge clk); #1 req2 = 1'b1;
      @(posedge clk); #1 req2 = 1'b0;
      n = 0;
      while (busy2 && n < 200) begin
         n++; @(posedge clk); #1;
      end
      chk("t4_busy_cycles", n, 18);
      chk("t4_timeout", to2, 1);
      chk("t4_na", na2, 0);

      // Simultaneous done and no_answer
      r0 = n_rows;
      run(30, 2);
      chk("t4_both_na", status_no_answer, 1);
      chk("t4_both_rows", n_rows - r0, 0);

      // Reset in the middle of the stream
      m_dly = 50; m_mode = 0;
      push_rows();
      @(posedge clk); #1 req = 1'b1;
      @(posedge clk); #1 req = 1'b0;
      wait_row(3'd4);
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      sb.delete();
      chk("t5_busy", busy, 0);
      chk("t5_outs", {solver_rst, solver_start, out_valid, row_last, status_no_answer, status_timeout}, 0);
      chk("t5_data", {rd_sel, out_idx, out_row}, 0);
      r0 = n_rows;
      run(50, 0);
      chk("t5_rows", n_rows - r0, 8);

      // Requests while busy are dropped
      r0 = n_rows; s0 = n_rst; st0 = n_start;
      fork
         run(50, 0);
         begin
            repeat (10) @(posedge clk);
            #1 req = 1'b1;
            @(posedge clk); #1 req = 1'b0;
            wait_row(3'd2);
            req = 1'b1;
            @(posedge clk); #1 req = 1'b0;
         end
      join
      repeat (4) @(posedge clk);
      #1;
      chk("t6_rows", n_rows - r0, 8);
      chk("t6_rst_pulses", n_rst - s0, 1);
      chk("t6_start_pulses", n_start - st0, 1);
      chk("t6_idle", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1, "simulation time limit");
   end

endmodule
`default_nettype wire
